// File: rtl/uart_tx.sv
// uart_tx: start/data/stop serial transmitter with a one-word holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert a parity bit after the data (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS);
  localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

  state_e               state_q;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 hold_full_q;
  logic [3:0]           bit_cnt_q;
  logic [1:0]           stop_cnt_q;
  logic                 tx_q;
  logic                 done_q;
  logic                 load_frame;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  // A queued word starts a frame from IDLE or straight off the final stop tick, so frames abut.
  assign load_frame = baud_tick && hold_full_q &&
                      ((state_q == IDLE) || ((state_q == STOP) && (stop_cnt_q == LAST_STOP)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;

      if (tx_start && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      if (baud_tick) begin
        unique case (state_q)
          IDLE: begin
            tx_q <= 1'b1;
          end
          START: begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= 4'd1;
            state_q   <= DATA;
          end
          DATA: begin
            if (bit_cnt_q < LAST_BIT) begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q       <= 1'b1;
              stop_cnt_q <= '0;
              state_q    <= STOP;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            tx_q       <= 1'b1;
            stop_cnt_q <= '0;
            state_q    <= STOP;
          end
`endif
          STOP: begin
            tx_q <= 1'b1;
            if (stop_cnt_q == LAST_STOP) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + 2'd1;
            end
          end
          default: begin
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end
        endcase

        // Later assignments override the case above when a new frame begins on this tick.
        if (load_frame) begin
          shift_q     <= hold_q;
          hold_full_q <= 1'b0;
          tx_q        <= 1'b0;
          state_q     <= START;
`ifdef UART_TX_PARITY_EN
          parity_q    <= (^hold_q) ^ PARITY_ODD;
`endif
        end
      end
    end
  end

  assign tx       = tx_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != IDLE) || hold_full_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: fixed 8N1 vector table, hand-written corner sequences and random traffic
// checked every cycle against a frame-level queue model. Follows UART_TX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int FRAME = 1 + DB + PB + SB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic          tx_start = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_ready, tx, tx_busy, tx_done;

  int assertCount = 0;
  int failCount   = 0;

  // Model: lineQ holds the bits still owed on the line; its head is the bit being driven now.
  logic          lineQ[$];
  logic          holdValid = 1'b0;
  logic [DB-1:0] holdWord = '0;
  logic          expDone = 1'b0;

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic       tick;
    logic       expTx;
    logic       expReady;
    logic       expBusy;
    logic       expDone;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_tick(baud_tick),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushFrame(input logic [DB-1:0] w);
    lineQ.push_back(1'b0);
    for (int i = 0; i < DB; i++) lineQ.push_back(w[i]);
    if (PB == 1) lineQ.push_back(^w);
    for (int i = 0; i < SB; i++) lineQ.push_back(1'b1);
  endtask

  task automatic modelStep(input logic start, input logic [DB-1:0] data, input logic tick);
    logic wasEmpty;
    wasEmpty = !holdValid;
    expDone  = 1'b0;
    if (tick) begin
      if (lineQ.size() > 0) begin
        void'(lineQ.pop_front());
        if (lineQ.size() == 0) expDone = 1'b1;
      end
      if (lineQ.size() == 0 && holdValid) begin
        pushFrame(holdWord);
        holdValid = 1'b0;
      end
    end
    if (start && wasEmpty) begin
      holdValid = 1'b1;
      holdWord  = data;
    end
  endtask

  task automatic checkModel();
    logic expTx;
    expTx = (lineQ.size() > 0) ? lineQ[0] : 1'b1;
    checkOutput("model tx",       32'(tx),       32'(expTx));
    checkOutput("model tx_ready", 32'(tx_ready), 32'(!holdValid));
    checkOutput("model tx_busy",  32'(tx_busy),  32'((lineQ.size() > 0) || holdValid));
    checkOutput("model tx_done",  32'(tx_done),  32'(expDone));
  endtask

  task automatic applyStimulus(input logic start, input logic [DB-1:0] data, input logic tick);
    @(negedge clk);
    tx_start  = start;
    tx_data   = data;
    baud_tick = tick;
    @(posedge clk);
    modelStep(start, data, tick);
    #1;
    tx_start  = 1'b0;
    baud_tick = 1'b0;
    checkModel();
  endtask

  task automatic tickOnce(output logic sawDone, output logic txAfter);
    applyStimulus(1'b0, '0, 1'b1);
    sawDone = tx_done;
    txAfter = tx;
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic runTicks(input int n);
    logic d, t;
    for (int i = 0; i < n; i++) tickOnce(d, t);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " tx"},       32'(tx),       32'd1);
    checkOutput({tag, " tx_busy"},  32'(tx_busy),  32'd0);
    checkOutput({tag, " tx_ready"}, 32'(tx_ready), 32'd1);
    checkOutput({tag, " tx_done"},  32'(tx_done),  32'd0);
    lineQ.delete();
    holdValid = 1'b0;
    expDone   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic d, t;
    int   tickIdx, firstDone, secondDone, doneCount;
    logic lastTick;

    $display("[TB] uart_tx bench start, frame length %0d ticks", FRAME);
    doReset("reset");
    applyStimulus(1'b0, '0, 1'b0);

`ifndef UART_TX_PARITY_EN
    // 0xA5 as 8N1: one accept cycle, then one row per baud tick.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].start, vecs[i].data, vecs[i].tick);
      checkOutput($sformatf("vec%0d tx", i),       32'(tx),       32'(vecs[i].expTx));
      checkOutput($sformatf("vec%0d tx_ready", i), 32'(tx_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d tx_busy", i),  32'(tx_busy),  32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d tx_done", i),  32'(tx_done),  32'(vecs[i].expDone));
      applyStimulus(1'b0, '0, 1'b0);
    end
`else
    // 0x07 with even parity and two stop bits: 0,1,1,1,0,0,0,0,0,P=1,1,1.
    begin
      logic [11:0] expBits;
      expBits = 12'b1110_0000_1110;
      applyStimulus(1'b1, 8'h07, 1'b0);
      for (int i = 0; i < 12; i++) begin
        tickOnce(d, t);
        checkOutput($sformatf("parity bit%0d", i), 32'(t), 32'(expBits[i]));
        checkOutput($sformatf("parity early done%0d", i), 32'(d), 32'd0);
      end
      tickOnce(d, t);
      checkOutput("parity frame done", 32'(d), 32'd1);
    end
`endif

    // Request coincident with a tick while idle: line stays high, start bit follows a tick later.
    applyStimulus(1'b1, 8'h96, 1'b1);
    checkOutput("coinc tx held high", 32'(tx), 32'd1);
    applyStimulus(1'b0, '0, 1'b0);
    tickOnce(d, t);
    checkOutput("coinc start bit", 32'(t), 32'd0);
    checkOutput("coinc start bit full period", 32'(tx), 32'd0);
    runTicks(FRAME + 1);

    // Back-to-back frames with an overrun attempt while the holding register is full.
    applyStimulus(1'b1, 8'h55, 1'b0);
    runTicks(3);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("queued ready low", 32'(tx_ready), 32'd0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("overrun ready low", 32'(tx_ready), 32'd0);
    firstDone  = -1;
    secondDone = -1;
    doneCount  = 0;
    for (tickIdx = 0; tickIdx < 2 * FRAME + 4; tickIdx++) begin
      tickOnce(d, t);
      if (d) begin
        doneCount++;
        if (firstDone < 0) firstDone = tickIdx;
        else if (secondDone < 0) secondDone = tickIdx;
      end
    end
    checkOutput("b2b done count", 32'(doneCount), 32'd2);
    checkOutput("b2b done spacing", 32'(secondDone - firstDone), 32'(FRAME));

    // Reset in the middle of the data bits of 0x3C, then a clean 0x81 frame.
    applyStimulus(1'b1, 8'h3C, 1'b0);
    runTicks(4);
    doReset("midframe reset");
    doneCount = 0;
    for (int i = 0; i < 4; i++) begin
      tickOnce(d, t);
      if (d) doneCount++;
    end
    checkOutput("no done after reset", 32'(doneCount), 32'd0);
    applyStimulus(1'b1, 8'h81, 1'b0);
    runTicks(FRAME + 2);

    // Random traffic; ticks never in consecutive cycles.
    lastTick = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic tk, st;
      tk = !lastTick && ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) == 0);
      applyStimulus(st, DB'($urandom), tk);
      lastTick = tk;
      if (c == 1500) doReset("random reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the sending end of the 8N1-style serial link that the receiver block decodes. It serialises a parallel word onto the tx line: start bit (0), then data LSB-first, then stop bit(s) (1). Each bit lasts exactly one baud_tick period. The baud_tick comes from the shared baud generator, the same one that feeds the receiver. A 1-entry holding register lets the host queue the next word during a frame, so back-to-back frames go out with no idle gap.

Parameters:
DATA_BITS, 8, data bits per frame (5..9).
STOP_BITS, 1, stop bits per frame (1 or 2).
PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
baud_tick  input  1  single-cycle strobe, one per bit period, from the baud generator.
tx_data  input  DATA_BITS  word to send; sampled on acceptance.
tx_start  input  1  request to send tx_data.
tx_ready  output  1  holding register empty; a request is accepted only while high.
tx  output  1  serial line, idle high; registered.
tx_busy  output  1  a frame is in flight or a word is queued.
tx_done  output  1  one-cycle pulse when the last stop bit period ends.

Behaviour:
- Reset (async on rst_n low, release sync): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, hold empty, shift/bit counters 0. Reset mid-frame aborts the frame at once. tx returns high with no partial stop bit.
- Acceptance: tx_start && tx_ready at a clk edge loads hold <= tx_data and sets hold full. tx_ready drops the next cycle.
- tx_start while tx_ready=0 is ignored. The held word and the frame in flight are unaffected.
- tx_ready = !hold_full (register-derived, no combinational path from tx_start).
- tx_busy = (state != IDLE) || hold_full.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP. All transitions occur only on clk edges with baud_tick=1. tx is registered and changes only on those edges.
- IDLE: tx=1. On baud_tick with hold full, do all of the following on that edge:
  - shift <= hold; clear hold.
  - tx <= 0; go to START.
- Acceptance and baud_tick in the same cycle while IDLE with hold empty: the word loads. Transmission starts on the next baud_tick, not the coincident one. This guarantees a full-length start bit.
- START: on baud_tick, tx <= shift[0], shift right, bit_cnt <= 1, go to DATA.
- DATA: on baud_tick, if bit_cnt < DATA_BITS, drive the next bit and increment bit_cnt. Otherwise go to PARITY (feature) or STOP, driving tx accordingly (parity bit or 1).
- STOP: tx=1. stop_cnt counts baud_ticks. On the tick that ends the STOP_BITS-th stop period:
  - tx_done=1 for that one cycle.
  - If hold full: load shift from hold, clear hold, tx <= 0, go to START. No idle gap between frames.
  - Else: go to IDLE.
- Frame length: exactly 1 + DATA_BITS (+1 parity) + STOP_BITS baud periods, measured tick to tick.
- The host may queue a new word at any time while hold is empty, including during the tick that drains hold. Drain and load cannot collide, because tx_ready=0 whenever hold is full.
- baud_tick held high for several cycles is not supported; one-cycle strobes only.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted after the last data bit. tx = XOR of the data bits, XOR PARITY_ODD. Frames are one bit longer.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- 8N1, after reset, tx_start with 0xA5 while idle -> on successive baud_ticks tx = 0,1,0,1,0,0,1,0,1,1. tx_done pulses once at the end of the stop bit. tx_busy is 1 from acceptance until the tx_done cycle, then 0.
- Back-to-back: 0x55 accepted, then 0xAA accepted during the first frame's DATA phase -> the second start bit begins on the same tick that ends the first stop bit. Two tx_done pulses, exactly 10 ticks apart. tx_ready is 0 from the queue until the second frame starts.
- Overrun: with hold full, tx_start with 0xFF -> ignored. The transmitted frames carry only the previously accepted words.
- tx_start coincident with baud_tick in IDLE -> tx stays 1 for that tick. The start bit begins on the following tick and lasts a full period.
- Reset asserted mid-DATA of 0x3C -> tx=1, tx_busy=0, tx_ready=1 immediately, no tx_done. After release, 0x81 transmits correctly.
- UART_TX_PARITY_EN, PARITY_ODD=0, STOP_BITS=2, data 0x07 -> parity bit 1, then two stop periods. Frame = 12 ticks.
